fp_normalizer: RTL and testbench

- Two-stage pipelined post-addition normalizer for the FP datapath; it is the left-shift counterpart to the alignment right-shifter.
- It takes the raw 25-bit mantissa sum from the FP adder, with sign and pre-normalization exponent.
- It finds the leading one, then left-shifts the mantissa, or right-shifts by 1 on carry-out, and adjusts the exponent.
- It outputs an IEEE-754 single-precision sign/exponent/fraction, plus status flags, over a valid/ready handshake.

---
 rtl/fp_normalizer.sv | 176 +++++++++++++++++
 tb/tb_fp_normalizer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Two-stage post-addition normalizer: stage 1 classifies the sum and counts leading zeros,
// stage 2 shifts the mantissa, adjusts the exponent and raises zero/overflow/underflow flags.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exp,
  output logic [22:0] out_frac,
  output logic        out_zero,
  output logic        out_ovf,
  output logic        out_unf
);

  typedef enum logic [1:0] {
    CLS_NORM    = 2'd0,
    CLS_CARRY   = 2'd1,
    CLS_ZERO    = 2'd2,
    CLS_SPECIAL = 2'd3
  } cls_t;

  logic        w_s1_adv;
  logic        w_s2_adv;
  logic [4:0]  w_lz;
  cls_t        w_cls;

  logic        r_s1_valid;
  logic        r_s1_sign;
  logic [7:0]  r_s1_exp;
  logic [23:0] r_s1_mant;
  logic [4:0]  r_s1_lz;
  cls_t        r_s1_cls;

  logic        r_out_valid;
  logic        r_out_sign;
  logic [7:0]  r_out_exp;
  logic [22:0] r_out_frac;
  logic        r_out_zero;
  logic        r_out_ovf;
  logic        r_out_unf;

  logic [8:0]  w_exp9;
  logic [8:0]  w_lz9;
  logic [8:0]  w_exp_inc;
  logic [8:0]  w_exp_dec;
  logic [22:0] w_shift [0:5];
  logic [7:0]  w_nxt_exp;
  logic [22:0] w_nxt_frac;
  logic        w_nxt_zero;
  logic        w_nxt_ovf;
  logic        w_nxt_unf;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Highest set bit wins: later loop iterations overwrite earlier ones.
  always_comb begin
    w_lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (in_mant[i]) w_lz = 5'(23 - i);
    end
  end

  always_comb begin
    if (in_exp == 8'hFF)        w_cls = CLS_SPECIAL;
    else if (in_mant[24])       w_cls = CLS_CARRY;
    else if (in_mant == 25'd0)  w_cls = CLS_ZERO;
    else                        w_cls = CLS_NORM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= 8'd0;
      r_s1_mant  <= 24'd0;
      r_s1_lz    <= 5'd0;
      r_s1_cls   <= CLS_NORM;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_sign;
        r_s1_exp  <= in_exp;
        r_s1_mant <= in_mant[23:0];
        r_s1_lz   <= w_lz;
        r_s1_cls  <= w_cls;
      end
    end
  end

  // The hidden bit always shifts out of the 23-bit window, so only mant[22:0] feeds the shifter.
  assign w_shift[0] = r_s1_mant[22:0];
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_shift
      assign w_shift[gi+1] = r_s1_lz[gi] ? (w_shift[gi] << (2 ** gi)) : w_shift[gi];
    end
  endgenerate

  assign w_exp9    = {1'b0, r_s1_exp};
  assign w_lz9     = {4'd0, r_s1_lz};
  assign w_exp_inc = w_exp9 + 9'd1;
  assign w_exp_dec = w_exp9 - w_lz9;

  always_comb begin
    w_nxt_exp  = 8'd0;
    w_nxt_frac = 23'd0;
    w_nxt_zero = 1'b0;
    w_nxt_ovf  = 1'b0;
    w_nxt_unf  = 1'b0;
    case (r_s1_cls)
      CLS_SPECIAL: begin
        w_nxt_exp  = 8'hFF;
        w_nxt_frac = r_s1_mant[22:0];
      end
      CLS_CARRY: begin
        if (w_exp_inc >= 9'd255) begin
          w_nxt_exp = 8'hFF;
          w_nxt_ovf = 1'b1;
        end else begin
          w_nxt_exp  = w_exp_inc[7:0];
          w_nxt_frac = r_s1_mant[23:1];
        end
      end
      CLS_ZERO: begin
        w_nxt_zero = 1'b1;
      end
      default: begin
        if (w_exp9 > w_lz9) begin
          w_nxt_exp  = w_exp_dec[7:0];
          w_nxt_frac = w_shift[5];
        end else begin
          w_nxt_unf  = 1'b1;
          w_nxt_zero = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= 8'd0;
      r_out_frac  <= 23'd0;
      r_out_zero  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_unf   <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sign <= r_s1_sign;
        r_out_exp  <= w_nxt_exp;
        r_out_frac <= w_nxt_frac;
        r_out_zero <= w_nxt_zero;
        r_out_ovf  <= w_nxt_ovf;
        r_out_unf  <= w_nxt_unf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sign  = r_out_sign;
  assign out_exp   = r_out_exp;
  assign out_frac  = r_out_frac;
  assign out_zero  = r_out_zero;
  assign out_ovf   = r_out_ovf;
  assign out_unf   = r_out_unf;

endmodule

// File: tb/tb_fp_normalizer.sv
// Bench for fp_normalizer: vector table through a scoreboard, plus backpressure,
// latency and mid-flight reset sequences.
module tb_fp_normalizer;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic        e_sign;
    logic [7:0]  e_exp;
    logic [22:0] e_frac;
    logic        e_zero;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  int   n_checks;
  int   n_errors;
  int   n_txn;
  vec_t drv;
  vec_t sb[$];
  vec_t vecs[17];
  vec_t bp[4];
  logic        prev_stall;
  logic [34:0] held;
  logic        saw_in_ready_low;

  fp_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input vec_t v);
    bit ok;
    int budget;
    drv      = v;
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    ok       = 1'b0;
    budget   = 0;
    while (!ok && budget < 20) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [24:0] m,
                              input logic es, input logic [7:0] ee, input logic [22:0] ef,
                              input logic z, input logic o, input logic u);
    vec_t v;
    v.sign = s;  v.exp = e;  v.mant = m;
    v.e_sign = es; v.e_exp = ee; v.e_frac = ef;
    v.e_zero = z; v.e_ovf = o; v.e_unf = u;
    return v;
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    n_txn     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 25'd0;
    out_ready = 1'b1;
    prev_stall = 1'b0;
    held      = '0;
    saw_in_ready_low = 1'b0;

    //              sign exp    mant          e_sign e_exp  e_frac      z o u
    vecs[0]  = mk(0, 8'd127, 25'h0800000, 0, 8'd127, 23'h000000, 0, 0, 0);
    vecs[1]  = mk(0, 8'd127, 25'h1800000, 0, 8'd128, 23'h400000, 0, 0, 0);
    vecs[2]  = mk(0, 8'd254, 25'h1000000, 0, 8'd255, 23'h000000, 0, 1, 0);
    vecs[3]  = mk(0, 8'd100, 25'h0000001, 0, 8'd77,  23'h000000, 0, 0, 0);
    vecs[4]  = mk(0, 8'd24,  25'h0000001, 0, 8'd1,   23'h000000, 0, 0, 0);
    vecs[5]  = mk(0, 8'd23,  25'h0000001, 0, 8'd0,   23'h000000, 1, 0, 1);
    vecs[6]  = mk(1, 8'd90,  25'h0000000, 1, 8'd0,   23'h000000, 1, 0, 0);
    vecs[7]  = mk(0, 8'd255, 25'h0400001, 0, 8'd255, 23'h400001, 0, 0, 0);
    vecs[8]  = mk(0, 8'd10,  25'h0400003, 0, 8'd9,   23'h000006, 0, 0, 0);
    vecs[9]  = mk(0, 8'd50,  25'h0040001, 0, 8'd45,  23'h000020, 0, 0, 0);
    vecs[10] = mk(0, 8'd0,   25'h0800000, 0, 8'd0,   23'h000000, 1, 0, 1);
    vecs[11] = mk(1, 8'd255, 25'h1FFFFFF, 1, 8'd255, 23'h7FFFFF, 0, 0, 0);
    vecs[12] = mk(0, 8'd253, 25'h1C00003, 0, 8'd254, 23'h600001, 0, 0, 0);
    vecs[13] = mk(0, 8'd0,   25'h1000000, 0, 8'd1,   23'h000000, 0, 0, 0);
    vecs[14] = mk(1, 8'd200, 25'h0123456, 1, 8'd197, 23'h11A2B0, 0, 0, 0);
    vecs[15] = mk(1, 8'd6,   25'h0040000, 1, 8'd1,   23'h000000, 0, 0, 0);
    vecs[16] = mk(0, 8'd255, 25'h0000000, 0, 8'd255, 23'h000000, 0, 0, 0);

    bp[0] = mk(0, 8'd100, 25'h0800001, 0, 8'd100, 23'h000001, 0, 0, 0);
    bp[1] = mk(0, 8'd100, 25'h0400005, 0, 8'd99,  23'h00000A, 0, 0, 0);
    bp[2] = mk(0, 8'd100, 25'h0040003, 0, 8'd95,  23'h000060, 0, 0, 0);
    bp[3] = mk(0, 8'd100, 25'h0000001, 0, 8'd77,  23'h000000, 0, 0, 0);

    fork
      // Scoreboard monitor: samples on the falling edge, which precedes the accepting rising edge.
      forever begin
        @(negedge clk);
        if (rst) begin
          sb.delete();
          prev_stall = 1'b0;
        end else begin
          if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", 64'({out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf}),
                  64'(held));
          end
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_out: got beat exp=%0d frac=0x%0h, required no beat",
                       out_exp, out_frac);
            end else begin
              vec_t e;
              e = sb.pop_front();
              n_txn++;
              $display("txn %0d: in exp=%0d mant=0x%07h -> sign=%0b exp=%0d frac=0x%06h z=%0b o=%0b u=%0b",
                       n_txn, e.exp, e.mant, out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf);
              check("txn_result",
                    64'({out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf}),
                    64'({e.e_sign, e.e_exp, e.e_frac, e.e_zero, e.e_ovf, e.e_unf}));
            end
          end
          if (in_valid && in_ready) sb.push_back(drv);
          prev_stall = out_valid && !out_ready;
          held = {out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf};
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_fields", 64'({out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf}), 64'd0);

    // Latency: accepted at one edge, visible after the next.
    send(vecs[0]);
    check("lat_stage1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_stage2", 64'(out_valid), 64'd1);

    for (int i = 1; i < 17; i++) send(vecs[i]);
    drain();

    // Backpressure: stall the output for 3 cycles once the first result shows.
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp[i]);
      end
      begin
        int b;
        b = 0;
        while (!out_valid && b < 20) begin
          @(posedge clk);
          #1;
          b++;
        end
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw_in_ready_low = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    check("bp_in_ready_low", 64'(saw_in_ready_low), 64'd1);
    drain();

    // Reset with two beats in flight.
    send(vecs[1]);
    send(vecs[8]);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midrst_no_stale", 64'(out_valid), 64'd0);
    end
    send(vecs[14]);
    check("postrst_lat1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("postrst_lat2", 64'(out_valid), 64'd1);
    drain();
    check("txn_count", 64'(n_txn), 64'd22);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
